// File: rtl/sda_ctrl_pkg.sv
// Shared constants for the SDAccel kernel control register block:
// register byte offsets, ap_ctrl bit positions and control FSM states.
package sda_ctrl_pkg;

   localparam int unsigned OffsCtrl = 'h00;
   localparam int unsigned OffsGie  = 'h04;
   localparam int unsigned OffsIer  = 'h08;
   localparam int unsigned OffsIsr  = 'h0C;
   localparam int unsigned OffsArg0 = 'h10;

   localparam int unsigned BitApStart     = 0;
   localparam int unsigned BitApDone      = 1;
   localparam int unsigned BitApIdle      = 2;
   localparam int unsigned BitApReady     = 3;
   localparam int unsigned BitAutoRestart = 7;

   localparam int unsigned IsrDone  = 0;
   localparam int unsigned IsrReady = 1;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StStarting = 2'd1,
      StRunning  = 2'd2
   } ctrlState_t;

endpackage

// File: rtl/sda_kernel_control_regs_if.sv
// AXI4-Lite channel bundle between the host-side master and the control register slave.
interface sda_kernel_control_regs_if #(
   parameter int unsigned AddrWidth = 8
) ();

   logic                 sAxiAwValid;
   logic                 sAxiAwReady;
   logic [AddrWidth-1:0] sAxiAwAddr;
   logic                 sAxiWValid;
   logic                 sAxiWReady;
   logic [31:0]          sAxiWData;
   logic [3:0]           sAxiWStrb;
   logic                 sAxiBValid;
   logic                 sAxiBReady;
   logic [1:0]           sAxiBResp;
   logic                 sAxiArValid;
   logic                 sAxiArReady;
   logic [AddrWidth-1:0] sAxiArAddr;
   logic                 sAxiRValid;
   logic                 sAxiRReady;
   logic [31:0]          sAxiRData;
   logic [1:0]           sAxiRResp;

   modport slave (
      input  sAxiAwValid, sAxiAwAddr, sAxiWValid, sAxiWData, sAxiWStrb, sAxiBReady,
      input  sAxiArValid, sAxiArAddr, sAxiRReady,
      output sAxiAwReady, sAxiWReady, sAxiBValid, sAxiBResp,
      output sAxiArReady, sAxiRValid, sAxiRData, sAxiRResp
   );

   modport master (
      output sAxiAwValid, sAxiAwAddr, sAxiWValid, sAxiWData, sAxiWStrb, sAxiBReady,
      output sAxiArValid, sAxiArAddr, sAxiRReady,
      input  sAxiAwReady, sAxiWReady, sAxiBValid, sAxiBResp,
      input  sAxiArReady, sAxiRValid, sAxiRData, sAxiRResp
   );

endinterface

// File: rtl/sda_axil_slave_if.sv
// AXI4-Lite handshaking: turns the five channels into single-cycle register
// write (wrEn) and read (rdEn) strobes, with rdDone marking the R handshake.
module sda_axil_slave_if #(
   parameter int unsigned AddrWidth = 8
) (
   input  logic                     clk,
   input  logic                     rstN,
   sda_kernel_control_regs_if.slave axi,
   output logic                     wrEn,
   output logic [AddrWidth-1:0]     wrAddr,
   output logic [31:0]              wrData,
   output logic [3:0]               wrStrb,
   output logic                     rdEn,
   output logic [AddrWidth-1:0]     rdAddr,
   input  logic [31:0]              rdData,
   output logic                     rdDone
);

   logic                 live;
   logic                 awHeld, wHeld, bValid, rValid;
   logic [AddrWidth-1:0] awAddrQ;
   logic [31:0]          wDataQ, rDataQ;
   logic [3:0]           wStrbQ;
   logic                 awHs, wHs;

   // live keeps every ready low while in reset without a comb path from rstN
   assign axi.sAxiAwReady = live & ~awHeld & ~bValid;
   assign axi.sAxiWReady  = live & ~wHeld & ~bValid;
   assign axi.sAxiArReady = live & ~rValid;
   assign axi.sAxiBValid  = bValid;
   assign axi.sAxiBResp   = 2'b00;
   assign axi.sAxiRValid  = rValid;
   assign axi.sAxiRData   = rDataQ;
   assign axi.sAxiRResp   = 2'b00;

   assign awHs   = axi.sAxiAwValid & axi.sAxiAwReady;
   assign wHs    = axi.sAxiWValid & axi.sAxiWReady;
   assign wrEn   = awHeld & wHeld;
   assign wrAddr = awAddrQ;
   assign wrData = wDataQ;
   assign wrStrb = wStrbQ;
   assign rdEn   = axi.sAxiArValid & axi.sAxiArReady;
   assign rdAddr = axi.sAxiArAddr;
   assign rdDone = rValid & axi.sAxiRReady;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         live    <= 1'b0;
         awHeld  <= 1'b0;
         wHeld   <= 1'b0;
         bValid  <= 1'b0;
         rValid  <= 1'b0;
         awAddrQ <= '0;
         wDataQ  <= '0;
         wStrbQ  <= '0;
         rDataQ  <= '0;
      end else begin
         live <= 1'b1;
         if (awHs) begin
            awHeld  <= 1'b1;
            awAddrQ <= axi.sAxiAwAddr;
         end
         if (wHs) begin
            wHeld  <= 1'b1;
            wDataQ <= axi.sAxiWData;
            wStrbQ <= axi.sAxiWStrb;
         end
         if (wrEn) begin
            awHeld <= 1'b0;
            wHeld  <= 1'b0;
            bValid <= 1'b1;
         end else if (bValid && axi.sAxiBReady) begin
            bValid <= 1'b0;
         end
         if (rdEn) begin
            rValid <= 1'b1;
            rDataQ <= rdData;
         end else if (rdDone) begin
            rValid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sda_kernel_control_regs.sv
// SDAccel ap_ctrl_hs control registers, interrupt logic and kernel argument
// registers, handshaking go/done with the downstream kernel reset handler.
module sda_kernel_control_regs
   import sda_ctrl_pkg::*;
#(
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned NumArgs   = 4
) (
   input  logic                     clk,
   input  logic                     rstN,
   sda_kernel_control_regs_if.slave sAxi,
   output logic                     regGoValid,
   input  logic                     regGoHoldoff,
   input  logic                     regDoneValid,
   output logic                     regDoneStop,
   output logic [32*NumArgs-1:0]    kernelArgs,
   output logic                     interrupt
);

   logic                 wrEn, rdEn, rdDone;
   logic [AddrWidth-1:0] wrAddr, rdAddr;
   logic [31:0]          wrData, rdData;
   logic [3:0]           wrStrb;

   ctrlState_t           state, stateNext;
   logic                 apStart, apIdle, apDone, apReady, autoRestart;
   logic                 gie, gieNext;
   logic [1:0]           ier, ierNext, isr, isrNext;
   logic                 doneStopQ, rdCtrlPend, interruptQ;
   logic [31:0]          args [NumArgs];
   logic [NumArgs-1:0]   argWr;
   int unsigned          wrOff, rdOff;
   logic                 wrCtrl, wrGie, wrIer, wrIsr, startWr;
   logic                 goXfer, doneXfer, rdClr;

   sda_axil_slave_if #(.AddrWidth(AddrWidth)) uAxi (
      .clk    (clk),
      .rstN   (rstN),
      .axi    (sAxi),
      .wrEn   (wrEn),
      .wrAddr (wrAddr),
      .wrData (wrData),
      .wrStrb (wrStrb),
      .rdEn   (rdEn),
      .rdAddr (rdAddr),
      .rdData (rdData),
      .rdDone (rdDone)
   );

   // Only the low byte of the address is decoded; word-aligned offsets.
   always_comb begin
      wrOff   = 32'(wrAddr[7:0]) & ~32'd3;
      rdOff   = 32'(rdAddr[7:0]) & ~32'd3;
      wrCtrl  = wrEn & wrStrb[0] & (wrOff == OffsCtrl);
      wrGie   = wrEn & wrStrb[0] & (wrOff == OffsGie);
      wrIer   = wrEn & wrStrb[0] & (wrOff == OffsIer);
      wrIsr   = wrEn & wrStrb[0] & (wrOff == OffsIsr);
      startWr = wrCtrl & wrData[BitApStart] & apIdle;
      for (int unsigned k = 0; k < NumArgs; k++) begin
         argWr[k] = wrEn & apIdle & (wrOff == OffsArg0 + 4 * k);
      end
   end

   assign goXfer   = apStart & ~regGoHoldoff;
   assign doneXfer = regDoneValid & ~doneStopQ;
   assign rdClr    = rdDone & rdCtrlPend;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state <= StIdle;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         StIdle:     if (startWr)  stateNext = StStarting;
         StStarting: if (goXfer)   stateNext = StRunning;
         StRunning:  if (doneXfer) stateNext = autoRestart ? StStarting : StIdle;
         default:    stateNext = StIdle;
      endcase
   end

   always_comb begin
      apStart    = (state == StStarting);
      apIdle     = (state == StIdle);
      regGoValid = apStart;
   end

   // Hardware set wins over host toggle; interrupt tracks the post-update values.
   always_comb begin
      gieNext = wrGie ? wrData[0] : gie;
      ierNext = wrIer ? wrData[1:0] : ier;
      isrNext = isr ^ (wrIsr ? wrData[1:0] : 2'b00);
      if (doneXfer && ier[IsrDone])  isrNext[IsrDone]  = 1'b1;
      if (goXfer   && ier[IsrReady]) isrNext[IsrReady] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         apDone      <= 1'b0;
         apReady     <= 1'b0;
         autoRestart <= 1'b0;
         gie         <= 1'b0;
         ier         <= '0;
         isr         <= '0;
         doneStopQ   <= 1'b1;
         rdCtrlPend  <= 1'b0;
         interruptQ  <= 1'b0;
         for (int unsigned k = 0; k < NumArgs; k++) args[k] <= '0;
      end else begin
         doneStopQ  <= 1'b0;
         apDone     <= doneXfer | (apDone & ~rdClr);
         apReady    <= goXfer | (apReady & ~rdClr);
         gie        <= gieNext;
         ier        <= ierNext;
         isr        <= isrNext;
         interruptQ <= gieNext & |(isrNext & ierNext);
         if (wrCtrl) autoRestart <= wrData[BitAutoRestart];
         if (rdEn)   rdCtrlPend  <= (rdOff == OffsCtrl);
         for (int unsigned k = 0; k < NumArgs; k++) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (argWr[k] && wrStrb[b]) args[k][8*b +: 8] <= wrData[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rdData = '0;
      if (rdOff == OffsCtrl) begin
         rdData[BitApStart]     = apStart;
         rdData[BitApDone]      = apDone;
         rdData[BitApIdle]      = apIdle;
         rdData[BitApReady]     = apReady;
         rdData[BitAutoRestart] = autoRestart;
      end else if (rdOff == OffsGie) begin
         rdData[0] = gie;
      end else if (rdOff == OffsIer) begin
         rdData[1:0] = ier;
      end else if (rdOff == OffsIsr) begin
         rdData[1:0] = isr;
      end
      for (int unsigned k = 0; k < NumArgs; k++) begin
         if (rdOff == OffsArg0 + 4 * k) rdData = args[k];
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NumArgs; k++) kernelArgs[32*k +: 32] = args[k];
   end

   assign regDoneStop = doneStopQ;
   assign interrupt   = interruptQ;

endmodule

// File: tb/tb_sda_kernel_control_regs.sv
// Randomized self-checking bench for sda_kernel_control_regs against a
// transaction-level model of the control, interrupt and argument registers.
module tb_sda_kernel_control_regs;

   localparam int unsigned AW = 8;
   localparam int unsigned NA = 4;

   logic clk = 1'b0;
   logic rstN;
   logic regGoValid, regGoHoldoff, regDoneValid, regDoneStop, interrupt;
   logic [32*NA-1:0] kernelArgs;

   always #5 clk = ~clk;

   sda_kernel_control_regs_if #(.AddrWidth(AW)) bus ();

   sda_kernel_control_regs #(.AddrWidth(AW), .NumArgs(NA)) dut (
      .clk          (clk),
      .rstN         (rstN),
      .sAxi         (bus),
      .regGoValid   (regGoValid),
      .regGoHoldoff (regGoHoldoff),
      .regDoneValid (regDoneValid),
      .regDoneStop  (regDoneStop),
      .kernelArgs   (kernelArgs),
      .interrupt    (interrupt)
   );

   int checks = 0;
   int failures = 0;

   // Model: phase 0 idle, 1 waiting for go, 2 kernel running.
   int          mPhase;
   bit          mAuto, mDone, mReady, mGie;
   bit [1:0]    mIer, mIsr;
   logic [31:0] mArgs [NA];

   function automatic void modelReset();
      mPhase = 0; mAuto = 0; mDone = 0; mReady = 0; mGie = 0; mIer = 0; mIsr = 0;
      for (int k = 0; k < NA; k++) mArgs[k] = 0;
   endfunction

   function automatic logic [31:0] modelCtrl();
      logic [31:0] w;
      w = 0;
      w[0] = (mPhase == 1);
      w[1] = mDone;
      w[2] = (mPhase == 0);
      w[3] = mReady;
      w[7] = mAuto;
      return w;
   endfunction

   function automatic logic modelIrq();
      return mGie && ((mIsr & mIer) != 0);
   endfunction

   function automatic logic [32*NA-1:0] modelArgs();
      logic [32*NA-1:0] v;
      for (int k = 0; k < NA; k++) v[32*k +: 32] = mArgs[k];
      return v;
   endfunction

   function automatic logic [31:0] modelRead(input logic [7:0] addr);
      logic [31:0] v;
      v = 0;
      if (addr == 8'h00) v = modelCtrl();
      else if (addr == 8'h04) v = {31'd0, mGie};
      else if (addr == 8'h08) v = {30'd0, mIer};
      else if (addr == 8'h0C) v = {30'd0, mIsr};
      else if (addr >= 8'h10 && addr < 8'h10 + 4 * NA) v = mArgs[(addr - 8'h10) / 4];
      return v;
   endfunction

   function automatic void modelWrite(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s);
      if (addr == 8'h00 && s[0]) begin
         mAuto = d[7];
         if (mPhase == 0 && d[0]) mPhase = 1;
      end else if (addr == 8'h04 && s[0]) mGie = d[0];
      else if (addr == 8'h08 && s[0]) mIer = d[1:0];
      else if (addr == 8'h0C && s[0]) mIsr = mIsr ^ d[1:0];
      else if (addr >= 8'h10 && addr < 8'h10 + 4 * NA && mPhase == 0) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) mArgs[(addr - 8'h10) / 4][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   function automatic void modelGo();
      mReady = 1;
      if (mIer[1]) mIsr[1] = 1;
      mPhase = 2;
   endfunction

   function automatic void modelDoneEvt();
      mDone = 1;
      if (mIer[0]) mIsr[0] = 1;
      mPhase = mAuto ? 1 : 0;
   endfunction

   task automatic axiWrite(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      int t;
      logic awGo, wGo;
      resp = 2'b11;
      @(negedge clk);
      bus.sAxiAwAddr = addr; bus.sAxiAwValid = 1;
      bus.sAxiWData = d; bus.sAxiWStrb = s; bus.sAxiWValid = 1;
      bus.sAxiBReady = 1;
      t = 0;
      while ((bus.sAxiAwValid || bus.sAxiWValid) && t < 50) begin
         awGo = bus.sAxiAwValid && bus.sAxiAwReady;
         wGo  = bus.sAxiWValid && bus.sAxiWReady;
         @(posedge clk); #1;
         if (awGo) bus.sAxiAwValid = 0;
         if (wGo) bus.sAxiWValid = 0;
         t++;
         if (bus.sAxiAwValid || bus.sAxiWValid) @(negedge clk);
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.sAxiBValid && t < 50);
      checks++;
      if (!bus.sAxiBValid) begin
         failures++; $display("FAIL write_timeout addr=%h: bValid=0 required 1", addr);
         bus.sAxiAwValid = 0; bus.sAxiWValid = 0;
      end else begin
         resp = bus.sAxiBResp;
         @(posedge clk); #1;
      end
      bus.sAxiBReady = 0;
   endtask

   task automatic axiRead(input logic [7:0] addr, output logic [31:0] d);
      int t;
      d = 'x;
      @(negedge clk);
      bus.sAxiArAddr = addr; bus.sAxiArValid = 1; bus.sAxiRReady = 1;
      t = 0;
      while (bus.sAxiArValid && t < 50) begin
         if (bus.sAxiArReady) begin @(posedge clk); #1; bus.sAxiArValid = 0; end
         else @(negedge clk);
         t++;
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.sAxiRValid && t < 50);
      checks++;
      if (!bus.sAxiRValid) begin
         failures++; $display("FAIL read_timeout addr=%h: rValid=0 required 1", addr);
         bus.sAxiArValid = 0;
      end else begin
         d = bus.sAxiRData;
         @(posedge clk); #1;
      end
      bus.sAxiRReady = 0;
   endtask

   // Read a register and compare against the model, applying clear-on-read.
   task automatic readCheck(input string name, input logic [7:0] addr);
      logic [31:0] got, exp;
      exp = modelRead(addr);
      axiRead(addr, got);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL %s addr=%h: read %h required %h", name, addr, got, exp); end
      if (addr == 8'h00) begin mDone = 0; mReady = 0; end
   endtask

   task automatic writeModel(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s);
      logic [1:0] r;
      axiWrite(addr, d, s, r);
      modelWrite(addr, d, s);
      checks++;
      if (r !== 2'b00) begin failures++; $display("FAIL bresp addr=%h: %b required 00", addr, r); end
   endtask

   task automatic waitGoTaken();
      int t;
      t = 0;
      while (regGoValid && t < 30) begin @(negedge clk); t++; end
      checks++;
      if (regGoValid !== 1'b0) begin failures++; $display("FAIL go_timeout: regGoValid=%b required 0", regGoValid); end
      modelGo();
   endtask

   task automatic startAndGo();
      writeModel(8'h00, {24'd0, mAuto, 7'd1}, 4'hF);
      waitGoTaken();
   endtask

   task automatic donePulse();
      @(negedge clk); regDoneValid = 1;
      @(negedge clk); regDoneValid = 0;
      modelDoneEvt();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({regGoValid, regDoneStop, interrupt} !== 3'b010) begin
         failures++; $display("FAIL reset_ctrl_out: go/stop/irq=%b required 010", {regGoValid, regDoneStop, interrupt});
      end
      checks++;
      if ({bus.sAxiAwReady, bus.sAxiWReady, bus.sAxiArReady, bus.sAxiBValid, bus.sAxiRValid} !== 5'b0) begin
         failures++; $display("FAIL reset_axi_out: %b required 00000",
            {bus.sAxiAwReady, bus.sAxiWReady, bus.sAxiArReady, bus.sAxiBValid, bus.sAxiRValid});
      end
      @(negedge clk); rstN = 1;
      @(negedge clk);
      checks++;
      if (regDoneStop !== 1'b0) begin failures++; $display("FAIL reset_done_stop: %b required 0", regDoneStop); end
      readCheck("reset_ctrl", 8'h00);
      readCheck("reset_isr", 8'h0C);
   endtask

   task automatic test_start_holdoff();
      regGoHoldoff = 1;
      writeModel(8'h00, 32'h1, 4'hF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (regGoValid !== 1'b1) begin failures++; $display("FAIL go_held cycle %0d: %b required 1", i, regGoValid); end
      end
      regGoHoldoff = 0;
      @(negedge clk);
      checks++;
      if (regGoValid !== 1'b0) begin failures++; $display("FAIL go_drop: %b required 0", regGoValid); end
      modelGo();
      readCheck("ready_set", 8'h00);
      readCheck("ready_cleared", 8'h00);
   endtask

   task automatic test_done();
      @(negedge clk); regDoneValid = 1;
      checks++;
      if (regDoneStop !== 1'b0) begin failures++; $display("FAIL done_stop: %b required 0", regDoneStop); end
      @(negedge clk); regDoneValid = 0;
      modelDoneEvt();
      readCheck("done_set", 8'h00);
      readCheck("done_cleared", 8'h00);
   endtask

   task automatic test_interrupt();
      writeModel(8'h04, 32'h1, 4'hF);
      writeModel(8'h08, 32'h1, 4'hF);
      startAndGo();
      @(negedge clk);
      checks++;
      if (interrupt !== modelIrq()) begin failures++; $display("FAIL irq_before: %b required %b", interrupt, modelIrq()); end
      donePulse();
      checks++;
      if (interrupt !== modelIrq()) begin failures++; $display("FAIL irq_on_done: %b required %b", interrupt, modelIrq()); end
      writeModel(8'h0C, 32'h1, 4'hF);
      @(negedge clk);
      checks++;
      if (interrupt !== modelIrq()) begin failures++; $display("FAIL irq_cleared: %b required %b", interrupt, modelIrq()); end
      startAndGo();
      donePulse();
      startAndGo();
      // Toggle write and done transfer land on the same clock edge.
      @(negedge clk);
      bus.sAxiAwAddr = 8'h0C; bus.sAxiAwValid = 1;
      bus.sAxiWData = 32'h1; bus.sAxiWStrb = 4'hF; bus.sAxiWValid = 1; bus.sAxiBReady = 0;
      @(posedge clk); #1; bus.sAxiAwValid = 0; bus.sAxiWValid = 0;
      @(negedge clk); regDoneValid = 1;
      @(negedge clk); regDoneValid = 0;
      modelWrite(8'h0C, 32'h1, 4'hF);
      modelDoneEvt();
      checks++;
      if (bus.sAxiBValid !== 1'b1) begin failures++; $display("FAIL simul_b: bValid=%b required 1", bus.sAxiBValid); end
      bus.sAxiBReady = 1;
      @(posedge clk); #1; bus.sAxiBReady = 0;
      readCheck("isr_set_wins", 8'h0C);
      checks++;
      if (interrupt !== modelIrq()) begin failures++; $display("FAIL irq_set_wins: %b required %b", interrupt, modelIrq()); end
   endtask

   task automatic test_args();
      logic [7:0]  a;
      logic [31:0] d, junk;
      logic [3:0]  s;
      logic [1:0]  r;
      writeModel(8'h10, 32'hDEADBEEF, 4'b0011);
      checks++;
      if (kernelArgs[31:0] !== 32'h0000BEEF) begin failures++; $display("FAIL arg0_strobe: %h required 0000beef", kernelArgs[31:0]); end
      for (int i = 0; i < 10; i++) begin
         a = 8'(8'h10 + 4 * $urandom_range(0, NA - 1));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         writeModel(a, d, s);
         checks++;
         if (kernelArgs !== modelArgs()) begin failures++; $display("FAIL arg_rand %0d: %h required %h", i, kernelArgs, modelArgs()); end
         readCheck("arg_readback", a);
      end
      startAndGo();
      junk = $urandom;
      axiWrite(8'h14, junk, 4'hF, r);
      modelWrite(8'h14, junk, 4'hF);
      checks++;
      if (r !== 2'b00) begin failures++; $display("FAIL arg_running_resp: %b required 00", r); end
      checks++;
      if (kernelArgs !== modelArgs()) begin failures++; $display("FAIL arg_running_hold: %h required %h", kernelArgs, modelArgs()); end
      donePulse();
      readCheck("ctrl_after_args", 8'h00);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [1:0]  r;
      int t, hi;
      d = $urandom;
      @(negedge clk);
      bus.sAxiWData = d; bus.sAxiWStrb = 4'hF; bus.sAxiWValid = 1; bus.sAxiBReady = 0;
      @(posedge clk); #1; bus.sAxiWValid = 0;
      repeat (3) @(negedge clk);
      bus.sAxiAwAddr = 8'h18; bus.sAxiAwValid = 1;
      @(posedge clk); #1; bus.sAxiAwValid = 0;
      modelWrite(8'h18, d, 4'hF);
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.sAxiBValid && t < 20);
      hi = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.sAxiBValid) hi++;
         @(negedge clk);
      end
      checks++;
      if (hi != 4) begin failures++; $display("FAIL b_held: high %0d cycles required 4", hi); end
      bus.sAxiBReady = 1;
      @(posedge clk); #1; bus.sAxiBReady = 0;
      hi = 0;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.sAxiBValid) hi++; end
      checks++;
      if (hi != 0) begin failures++; $display("FAIL b_single: extra bValid %0d cycles required 0", hi); end
      checks++;
      if (kernelArgs !== modelArgs()) begin failures++; $display("FAIL w_before_aw: %h required %h", kernelArgs, modelArgs()); end
      axiWrite(8'h3C, $urandom, 4'hF, r);
      checks++;
      if (r !== 2'b00 || kernelArgs !== modelArgs()) begin
         failures++; $display("FAIL unmapped_write: resp %b args %h required 00 %h", r, kernelArgs, modelArgs());
      end
      readCheck("unmapped_3c", 8'h3C);
      readCheck("unmapped_20", 8'h20);
   endtask

   task automatic test_autorestart();
      writeModel(8'h00, 32'h80, 4'hF);
      readCheck("auto_idle", 8'h00);
      writeModel(8'h00, 32'h81, 4'hF);
      waitGoTaken();
      donePulse();
      checks++;
      if (regGoValid !== 1'b1) begin failures++; $display("FAIL auto_rego1: %b required 1", regGoValid); end
      waitGoTaken();
      readCheck("auto_running", 8'h00);
      regGoHoldoff = 1;
      donePulse();
      checks++;
      if (regGoValid !== 1'b1) begin failures++; $display("FAIL auto_rego2: %b required 1", regGoValid); end
      readCheck("auto_starting", 8'h00);
   endtask

   task automatic test_reset_midrun();
      @(posedge clk); #2;
      bus.sAxiArAddr = 8'h00; bus.sAxiArValid = 1; bus.sAxiRReady = 0;
      #1 rstN = 0;
      #1;
      checks++;
      if ({regGoValid, regDoneStop, interrupt} !== 3'b010) begin
         failures++; $display("FAIL midrun_ctrl_out: go/stop/irq=%b required 010", {regGoValid, regDoneStop, interrupt});
      end
      checks++;
      if (kernelArgs !== '0) begin failures++; $display("FAIL midrun_args: %h required 0", kernelArgs); end
      checks++;
      if ({bus.sAxiArReady, bus.sAxiRValid, bus.sAxiBValid} !== 3'b0) begin
         failures++; $display("FAIL midrun_axi: %b required 000", {bus.sAxiArReady, bus.sAxiRValid, bus.sAxiBValid});
      end
      bus.sAxiArValid = 0;
      regGoHoldoff = 0;
      modelReset();
      @(negedge clk); rstN = 1;
      @(negedge clk);
      readCheck("post_reset_ctrl", 8'h00);
      readCheck("post_reset_gie", 8'h04);
      readCheck("post_reset_arg0", 8'h10);
   endtask

   initial begin
      rstN = 0;
      regGoHoldoff = 0; regDoneValid = 0;
      bus.sAxiAwValid = 0; bus.sAxiAwAddr = '0;
      bus.sAxiWValid = 0; bus.sAxiWData = '0; bus.sAxiWStrb = '0;
      bus.sAxiBReady = 0;
      bus.sAxiArValid = 0; bus.sAxiArAddr = '0; bus.sAxiRReady = 0;
      modelReset();
      test_reset();
      test_start_holdoff();
      test_done();
      test_interrupt();
      test_args();
      test_back_to_back();
      test_autorestart();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
